// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: diff = a - b over WIDTH cycles.
// Optional SERIAL_SUB_OVF_EN adds a registered two's-complement overflow flag (ovf).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb;
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_nx;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             ai, bi, d, bout, last;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb, b_msb;
`endif

    // Single full-subtractor cell; res_nx is the result with the current bit on top
    always_comb begin
        ai     = sa[0];
        bi     = sb[0];
        d      = ai ^ bi ^ brw;
        bout   = (~ai & bi) | (~(ai ^ bi) & brw);
        res_nx = {d, res};
        last   = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    sa    <= a;
                    sb    <= b;
                    brw   <= 1'b0;
                    cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb <= a[WIDTH-1];
                    b_msb <= b[WIDTH-1];
`endif
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= res_nx[WIDTH-1:1];
                    brw <= bout;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        diff       <= res_nx;
                        borrow_out <= bout;
`ifdef SERIAL_SUB_OVF_EN
                        ovf        <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle-timed arithmetic model plus directed literals.
// Define SERIAL_SUB_OVF_EN to also check the ovf output.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int pass_cnt = 0;
    int tot_cnt  = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf        (ovf),
`endif
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    // Model: m_age counts edges since the accepting edge; busy for ages 0..W-1, done at age W
    logic         m_active;
    int           m_age;
    logic [W-1:0] m_a, m_b, m_diff;
    logic         m_brw, m_ovf;
    logic [W-1:0] m_sub;

    assign m_sub = m_a - m_b;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_a      <= '0;
            m_b      <= '0;
            m_diff   <= '0;
            m_brw    <= 1'b0;
            m_ovf    <= 1'b0;
        end else if (m_active) begin
            if (m_age == W - 1) begin
                m_diff <= m_sub;
                m_brw  <= (m_a < m_b);
                m_ovf  <= (m_a[W-1] != m_b[W-1]) && (m_sub[W-1] != m_a[W-1]);
            end
            if (m_age == W) m_active <= 1'b0;
            m_age <= m_age + 1;
        end else if (start) begin
            m_active <= 1'b1;
            m_age    <= 0;
            m_a      <= a;
            m_b      <= b;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("cyc_busy", {31'b0, busy}, {31'b0, m_active && (m_age < W)});
        chk("cyc_done", {31'b0, done}, {31'b0, m_active && (m_age == W)});
        chk("cyc_diff", {24'b0, diff}, {24'b0, m_diff});
        chk("cyc_borrow", {31'b0, borrow_out}, {31'b0, m_brw});
`ifdef SERIAL_SUB_OVF_EN
        chk("cyc_ovf", {31'b0, ovf}, {31'b0, m_ovf});
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue one operation from IDLE and pin the result against hand-computed literals
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        int  nb;
        bit  seen;
        nb   = 0;
        seen = 0;
        a = ta; b = tb_; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4 * W && !seen; i++) begin
            if (done) seen = 1;
            else begin
                if (busy) nb++;
                tick();
            end
        end
        if (!seen) begin
            tot_cnt++;
            $display("FAIL op_timeout: no done for a=%0h b=%0h", ta, tb_);
        end else begin
            chk("op_diff", {24'b0, diff}, {24'b0, ed});
            chk("op_borrow", {31'b0, borrow_out}, {31'b0, eb});
            chk("op_busy_cycles", nb, W);
`ifdef SERIAL_SUB_OVF_EN
            chk("op_ovf", {31'b0, ovf}, {31'b0, eo});
`else
            if (eo === 1'bx) $display("unexpected X ovf literal");
`endif
        end
        tick();
    endtask

    initial begin
        int ndone;
        #1 reset_n = 1'b0;
        #20;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_diff", {24'b0, diff}, 32'd0);
        chk("rst_borrow", {31'b0, borrow_out}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        run_op(8'h5A, 8'h1C, 8'h3E, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
        run_op(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

        // Start pulse mid-operation must be ignored
        a = 8'h80; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        a = 8'h01; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 3 * W; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("ign_done_count", ndone, 1);
        chk("ign_diff", {24'b0, diff}, 32'h7F);
        chk("ign_busy_after", {31'b0, busy}, 32'd0);

        // Asynchronous reset in the middle of SHIFT
        a = 8'h5A; b = 8'h33; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        #1 reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_diff", {24'b0, diff}, 32'd0);
        chk("arst_borrow", {31'b0, borrow_out}, 32'd0);
        #3 reset_n = 1'b1;
        tick();
        run_op(8'h03, 8'h01, 8'h02, 1'b0, 1'b0);

        // Randomized operations with random gaps and ignored mid-op starts
        for (int n = 0; n < 60; n++) begin
            int gap;
            bit seen;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            a = W'($urandom); b = W'($urandom); start = 1'b1;
            tick();
            start = 1'b0;
            seen = 0;
            for (int i = 0; i < 4 * W && !seen; i++) begin
                if (done) seen = 1;
                else begin
                    a = W'($urandom); b = W'($urandom);
                    start = ($urandom_range(0, 3) == 0);
                    tick();
                    start = 1'b0;
                end
            end
            if (!seen) begin
                tot_cnt++;
                $display("FAIL rnd_timeout: op %0d never completed", n);
            end
            tick();
        end

        tick();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
